hazard_stall_unit: RTL

// - Consumes decoded control signals (mem_read, reg_write, jump/branch) and register indices from ID/EX.
// - Generates pipeline write-enables, bubbles and flushes for the 5-stage core with a MULT_LAT-cycle multiplier in EX.
// - Handles three hazards: load-use stalls, multi-cycle multiply holds and taken-branch/jump redirect flushes.
// - Keeps saturating performance counters for stall cycles.

---
 rtl/hazard_stall_unit_pkg.sv | 48 ++++
 rtl/hazard_stall_unit_if.sv | 34 +++
 rtl/hazard_stall_unit_sat_counter.sv | 28 ++
 rtl/hazard_stall_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared core definitions for the hazard/stall unit: opcodes, MUL funct7,
// FSM states, the pipeline-control bundle and the load-use detector.
package hazard_stall_unit_pkg;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_MULT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic ex_mem_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                      id_ex_bubble: 1'b0, if_id_flush: 1'b0, ex_mem_bubble: 1'b0};
  localparam pipe_ctrl_t CTRL_MULT = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                       id_ex_bubble: 1'b0, if_id_flush: 1'b0, ex_mem_bubble: 1'b1};
  localparam pipe_ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                           id_ex_bubble: 1'b1, if_id_flush: 1'b1, ex_mem_bubble: 1'b0};
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
                                           id_ex_bubble: 1'b1, if_id_flush: 1'b0, ex_mem_bubble: 1'b0};

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2,
                                        input logic       uses_rs1,
                                        input logic       uses_rs2);
    return mem_read && (rd != 5'd0) &&
           ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-facing bundle: decoded ID/EX hazard inputs and the resulting
// register enables, bubbles and flushes.
interface hazard_stall_unit_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rd;
  logic       ex_is_mult;
  logic       ex_redirect;

  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_write;
  logic       id_ex_bubble;
  logic       if_id_flush;
  logic       ex_mem_bubble;
  logic       mult_busy;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_ex_mem_read, id_ex_rd, ex_is_mult, ex_redirect,
    input  pc_write, if_id_write, id_ex_write, id_ex_bubble,
           if_id_flush, ex_mem_bubble, mult_busy
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           id_ex_mem_read, id_ex_rd, ex_is_mult, ex_redirect,
    output pc_write, if_id_write, id_ex_write, id_ex_bubble,
           if_id_flush, ex_mem_bubble, mult_busy
  );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter used for the stall performance counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard unit for the 5-stage core: load-use stalls, multi-cycle MUL holds,
// redirect flushes, plus saturating stall counters.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int MULT_LAT = 3,
  parameter int PERF_W   = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  hazard_stall_unit_if.slave    hif,
  output logic [PERF_W-1:0]     perf_mult_stalls,
  output logic [PERF_W-1:0]     perf_lu_stalls
);

  localparam int CNT_W = (MULT_LAT > 2) ? $clog2(MULT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hz_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             mult_stall;
  logic             load_use;
  pipe_ctrl_t       ctrl;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg <= S_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The MUL's entry cycle already stalls from S_RUN; S_MULT covers the rest
  // and releases on the cycle the result is valid.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mult_stall = 1'b0;
    case (state_reg)
      S_RUN: begin
        if (hif.ex_is_mult) begin
          mult_stall = 1'b1;
          state_next = S_MULT;
          cnt_next   = CNT_LOAD;
        end
      end
      S_MULT: begin
        if (cnt_reg != '0) begin
          mult_stall = 1'b1;
          cnt_next   = cnt_reg - CNT_ONE;
        end else begin
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = S_RUN;
        cnt_next   = '0;
      end
    endcase
  end

  assign load_use = load_use_hit(hif.id_ex_mem_read, hif.id_ex_rd, hif.id_rs1,
                                 hif.id_rs2, hif.id_uses_rs1, hif.id_uses_rs2);

  // Redirect wins over load-use: the dependent instruction is being flushed anyway.
  always_comb begin
    ctrl = CTRL_RUN;
    if (!arst_n) begin
      ctrl = CTRL_RUN;
    end else if (mult_stall) begin
      ctrl = CTRL_MULT;
    end else if (hif.ex_redirect) begin
      ctrl = CTRL_REDIRECT;
    end else if (load_use) begin
      ctrl = CTRL_LOAD_USE;
    end
  end

  assign hif.pc_write      = ctrl.pc_write;
  assign hif.if_id_write   = ctrl.if_id_write;
  assign hif.id_ex_write   = ctrl.id_ex_write;
  assign hif.id_ex_bubble  = ctrl.id_ex_bubble;
  assign hif.if_id_flush   = ctrl.if_id_flush;
  assign hif.ex_mem_bubble = ctrl.ex_mem_bubble;
  assign hif.mult_busy     = (state_reg == S_MULT);

  sat_counter #(.WIDTH(PERF_W)) u_mult_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .inc   (mult_stall),
    .clr   (1'b0),
    .count (perf_mult_stalls)
  );

  sat_counter #(.WIDTH(PERF_W)) u_lu_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .inc   (load_use && !hif.ex_redirect && !mult_stall),
    .clr   (1'b0),
    .count (perf_lu_stalls)
  );

endmodule
